// File: rtl/keypad_decoder.sv
// keypad_decoder: debounces a 4x4 keypad scanned by a one-hot column sweep.
// Emits a 4-bit key code with single-cycle press/release strobes and holds
// the sweep frozen while a key is being qualified or held down.
module keypad_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RELEASE_CYCLES  = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    input  logic [3:0] row,
    output logic       key_hold,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_down
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEBOUNCE    = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_DEB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] REL_TERM = CNT_W'(RELEASE_CYCLES);

    // True when exactly one of the four lines is active.
    function automatic logic is_onehot4(input logic [3:0] v);
        logic r;
        case (v)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Line index with the MSB as index 0.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b1000: r = 2'd0;
            4'b0100: r = 2'd1;
            4'b0010: r = 2'd2;
            4'b0001: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Key code from a captured {row, col} pair: row_idx*4 + col_idx.
    function automatic logic [3:0] code_of(input logic [7:0] pat);
        return {onehot_idx(pat[7:4]), onehot_idx(pat[3:0])};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cap_q, cap_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_release_q, key_release_d;
    logic             key_down_q, key_down_d;

    logic             sample_valid_s;
    logic             sample_match_s;
    logic             row_zero_s;
    logic [CNT_W-1:0] cnt_inc_s;

    // Sample qualification and saturating counter increment.
    always_comb begin
        sample_valid_s = is_onehot4(row) & is_onehot4(col);
        sample_match_s = ({row, col} == cap_q);
        row_zero_s     = (row == 4'b0000);
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
        end
    end

    // Freeze the sweep as soon as a valid key is seen and while one is active.
    always_comb begin
        key_hold = 1'b0;
        if (rst) begin
            key_hold = 1'b0;
        end else if (state_q != IDLE) begin
            key_hold = 1'b1;
        end else begin
            key_hold = sample_valid_s;
        end
    end

    // Next-state, counter, capture and strobe logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_d         = cap_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid_s) begin
                    cap_d = {row, col};
                    if (DEB_TERM == CNT_ONE) begin
                        state_d     = PRESSED;
                        cnt_d       = CNT_ZERO;
                        key_valid_d = 1'b1;
                        key_code_d  = code_of({row, col});
                    end else begin
                        state_d = DEBOUNCE;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end
            DEBOUNCE: begin
                if (sample_match_s) begin
                    if (cnt_inc_s == DEB_TERM) begin
                        state_d     = PRESSED;
                        cnt_d       = CNT_ZERO;
                        key_valid_d = 1'b1;
                        key_code_d  = code_of(cap_q);
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            PRESSED: begin
                if (row_zero_s) begin
                    if (REL_TERM == CNT_ONE) begin
                        state_d       = IDLE;
                        cnt_d         = CNT_ZERO;
                        key_release_d = 1'b1;
                    end else begin
                        state_d = RELEASE_DEB;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    state_d = PRESSED;
                end
            end
            RELEASE_DEB: begin
                if (row_zero_s) begin
                    if (cnt_inc_s == REL_TERM) begin
                        state_d       = IDLE;
                        cnt_d         = CNT_ZERO;
                        key_release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end else begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        key_down_d = (state_d == PRESSED) || (state_d == RELEASE_DEB);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= CNT_ZERO;
            cap_q         <= 8'h00;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_down_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cap_q         <= cap_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            key_down_q    <= key_down_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_down    = key_down_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Testbench for keypad_decoder: two instances (default timing and a
// single-sample press / two-sample release variant) share one stimulus
// stream; a reference model pushes expected strobes into per-instance
// queues and independent monitors pop and compare them.
module tb_keypad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col;
    logic [3:0] row;

    logic       hold0, valid0, rel0, down0;
    logic [3:0] code0;
    logic       hold1, valid1, rel1, down1;
    logic [3:0] code1;

    always #5 clk = ~clk;

    keypad_decoder #(.DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .key_hold(hold0), .key_code(code0), .key_valid(valid0),
        .key_release(rel0), .key_down(down0)
    );

    keypad_decoder #(.DEBOUNCE_CYCLES(1), .RELEASE_CYCLES(2), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .key_hold(hold1), .key_code(code1), .key_valid(valid1),
        .key_release(rel1), .key_down(down1)
    );

    typedef struct packed {
        logic        is_rel;
        logic [3:0]  code;
        logic [31:0] cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Reference model state, one slot per instance.
    int         DEB [2] = '{4, 1};
    int         REL [2] = '{4, 2};
    bit         m_pressed [2];
    int         m_run     [2];
    int         m_zrun    [2];
    logic [7:0] m_cand    [2];
    logic [3:0] m_code    [2];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        mon_en <= 1'b1;
    end

    function automatic bit onehot(input logic [3:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic logic [3:0] code_of(input logic [3:0] r, input logic [3:0] c);
        int ri = 0;
        int ci = 0;
        for (int i = 0; i < 4; i++) begin
            if (r[3-i]) ri = i;
            if (c[3-i]) ci = i;
        end
        return 4'(ri * 4 + ci);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int k, input bit rel, input logic [3:0] code);
        exp_t e;
        e.is_rel = rel;
        e.code   = code;
        e.cyc    = 32'(cyc + 1);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    function automatic bit q_has(input int k);
        return (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    endfunction

    function automatic exp_t q_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Advance the model by one sampling edge for instance k.
    task automatic model_step(input int k, input bit r, input logic [3:0] c, input logic [3:0] rw);
        if (r) begin
            m_pressed[k] = 1'b0;
            m_run[k]     = 0;
            m_zrun[k]    = 0;
            m_cand[k]    = 8'h00;
            m_code[k]    = 4'h0;
        end else if (!m_pressed[k]) begin
            if (m_run[k] == 0) begin
                if (onehot(c) && onehot(rw)) begin
                    m_cand[k] = {rw, c};
                    m_run[k]  = 1;
                end
            end else if ({rw, c} == m_cand[k]) begin
                m_run[k]++;
            end else begin
                m_run[k] = 0;
            end
            if (m_run[k] != 0 && m_run[k] == DEB[k]) begin
                m_pressed[k] = 1'b1;
                m_run[k]     = 0;
                m_zrun[k]    = 0;
                m_code[k]    = code_of(m_cand[k][7:4], m_cand[k][3:0]);
                push(k, 1'b0, m_code[k]);
            end
        end else begin
            if (rw == 4'b0000) m_zrun[k]++;
            else               m_zrun[k] = 0;
            if (m_zrun[k] == REL[k]) begin
                m_pressed[k] = 1'b0;
                m_zrun[k]    = 0;
                push(k, 1'b1, m_code[k]);
            end
        end
    endtask

    // One cycle of stimulus: drive, check hold mid-cycle, step model, check levels.
    task automatic apply(input bit r, input logic [3:0] c, input logic [3:0] rw);
        bit v;
        bit eh0, eh1;
        rst = r;
        col = c;
        row = rw;
        v   = onehot(c) && onehot(rw);
        eh0 = !r && (m_pressed[0] || m_run[0] != 0 || v);
        eh1 = !r && (m_pressed[1] || m_run[1] != 0 || v);
        @(negedge clk);
        chk("hold0", 32'(hold0), 32'(eh0));
        chk("hold1", 32'(hold1), 32'(eh1));
        model_step(0, r, c, rw);
        model_step(1, r, c, rw);
        @(posedge clk);
        #1;
        chk("down0", 32'(down0), 32'(m_pressed[0]));
        chk("code0", 32'(code0), 32'(m_code[0]));
        chk("down1", 32'(down1), 32'(m_pressed[1]));
        chk("code1", 32'(code1), 32'(m_code[1]));
    endtask

    task automatic mon(input int k, input logic v, input logic rl, input logic [3:0] code);
        exp_t e;
        while (q_has(k)) begin
            e = q_front(k);
            if (e.cyc >= 32'(cyc)) break;
            checks++;
            errors++;
            $display("FAIL missing_strobe dut%0d at cycle %0d: got none expected rel=%0d code=%0h at cycle %0d",
                     k, cyc, e.is_rel, e.code, e.cyc);
            q_pop(k);
        end
        if (v || rl) begin
            if (v && rl) begin
                checks++;
                errors++;
                $display("FAIL strobe_excl dut%0d at cycle %0d: got valid and release together expected one", k, cyc);
            end
            if (!q_has(k)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe dut%0d at cycle %0d: got valid=%0d rel=%0d expected none", k, cyc, v, rl);
            end else begin
                e = q_front(k);
                if (e.cyc == 32'(cyc)) begin
                    q_pop(k);
                    chk($sformatf("strobe_kind%0d", k), 32'({v, rl}), 32'({!e.is_rel, e.is_rel}));
                    chk($sformatf("strobe_code%0d", k), 32'(code), 32'(e.code));
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL early_strobe dut%0d at cycle %0d: got strobe expected at cycle %0d", k, cyc, e.cyc);
                end
            end
        end
    endtask

    // Strobe monitors, independent of the driver.
    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, valid0, rel0, code0);
            mon(1, valid1, rel1, code1);
        end
    end

    initial begin
        logic [3:0] one;
        logic [3:0] cv, rv;
        int len, p;
        one = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            m_pressed[k] = 1'b0;
            m_run[k]     = 0;
            m_zrun[k]    = 0;
            m_cand[k]    = 8'h00;
            m_code[k]    = 4'h0;
        end
        rst = 1'b1;
        col = 4'b0010;
        row = 4'b0100;
        @(posedge clk);
        #1;

        // Reset with a valid key present.
        repeat (2) apply(1'b1, 4'b0010, 4'b0100);
        // Clean press, then release.
        repeat (6) apply(1'b0, 4'b0010, 4'b0100);
        repeat (5) apply(1'b0, 4'b0010, 4'b0000);
        // Press bounce followed by a steady press.
        apply(1'b0, 4'b0010, 4'b0100);
        apply(1'b0, 4'b0010, 4'b0000);
        apply(1'b0, 4'b0010, 4'b0100);
        apply(1'b0, 4'b0010, 4'b0100);
        apply(1'b0, 4'b0010, 4'b0000);
        repeat (5) apply(1'b0, 4'b0010, 4'b0100);
        // Release bounce.
        apply(1'b0, 4'b0010, 4'b0000);
        apply(1'b0, 4'b0010, 4'b0000);
        apply(1'b0, 4'b0010, 4'b0100);
        repeat (5) apply(1'b0, 4'b0010, 4'b0000);
        // Invalid patterns in idle.
        repeat (2) apply(1'b0, 4'b0010, 4'b0110);
        repeat (2) apply(1'b0, 4'b0011, 4'b0100);
        // Second key while pressed.
        repeat (5) apply(1'b0, 4'b0010, 4'b0100);
        repeat (3) apply(1'b0, 4'b0010, 4'b0001);
        repeat (5) apply(1'b0, 4'b0010, 4'b0000);
        // Reset in the middle of debounce, after a held key set key_code.
        repeat (5) apply(1'b0, 4'b0001, 4'b1000);
        repeat (5) apply(1'b0, 4'b0001, 4'b0000);
        repeat (2) apply(1'b0, 4'b0010, 4'b0100);
        apply(1'b1, 4'b0010, 4'b0100);
        repeat (2) apply(1'b0, 4'b0000, 4'b0000);

        // Randomized key bursts with bounce, noise and occasional reset.
        for (int b = 0; b < 300; b++) begin
            cv  = one >> $urandom_range(0, 3);
            rv  = one >> $urandom_range(0, 3);
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                p = $urandom_range(0, 39);
                if (p == 0)       apply(1'b1, cv, rv);
                else if (p < 7)   apply(1'b0, cv, 4'b0000);
                else if (p < 10)  apply(1'b0, cv, 4'($urandom_range(0, 15)));
                else if (p < 12)  apply(1'b0, 4'($urandom_range(0, 15)), rv);
                else              apply(1'b0, cv, rv);
            end
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                p = $urandom_range(0, 9);
                if (p < 2) apply(1'b0, cv, rv);
                else       apply(1'b0, cv, 4'b0000);
            end
        end

        repeat (4) apply(1'b0, 4'b0000, 4'b0000);
        chk("pending_q0", 32'(q0.size()), 32'd0);
        chk("pending_q1", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
